pad_bank_inout_filt: RTL and testbench

//  Parametrised bank of NUM_PADS bidirectional pad simulation models. Each channel has a

---
 rtl/pad_bank_pkg.sv | 19 +
 rtl/pad_debounce.sv | 76 +++++++
 rtl/pad_bank_inout_filt.sv | 65 ++++++
 tb/tb_pad_bank_inout_filt.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pad_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pad_bank_pkg
//  Description : Shared constants and types for the pad bank model.
//  Revision    : 1.0  initial release
// ============================================================================
package pad_bank_pkg;

  // Legal range for the input synchroniser depth
  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;

  // Default per-pad attribute width (drive strength / pull configuration)
  localparam int PAD_ATTR_W = 16;

  typedef logic [PAD_ATTR_W-1:0] pad_attr_t;

endpackage
`default_nettype wire

// File: rtl/pad_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pad_debounce
//  Description : One pad input path: synchroniser chain, debounce counter
//                with shared threshold, and edge-detect pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module pad_debounce
  import pad_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              d_i,
  input  logic              en_i,
  input  logic [FILT_W-1:0] thresh_i,
  output logic              sync_o,
  output logic              filt_o,
  output logic              rise_o,
  output logic              fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   sample;
  logic                   sync_lvl;

  // Floating or unknown pad levels are read as logic 0
  assign sample   = (d_i === 1'b1);
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Next-state: shift the synchroniser and run the debounce counter
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sample};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!en_i) begin
      filt_d = sync_lvl;
      cnt_d  = '0;
    end else if (sync_lvl == filt_q) begin
      cnt_d  = '0;
    end else if (cnt_q >= thresh_i) begin
      // ">=" so a threshold lowered mid-count updates next cycle instead of wrapping
      filt_d = sync_lvl;
      cnt_d  = '0;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // State registers; reset clears everything so no edge is seen on release
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
    end
  end

  assign sync_o = sync_lvl;
  assign filt_o = filt_q;
  assign rise_o = filt_q & ~filt_prev_q;
  assign fall_o = ~filt_q & filt_prev_q;

endmodule
`default_nettype wire

// File: rtl/pad_bank_inout_filt.sv
`default_nettype none
// ============================================================================
//  Module      : pad_bank_inout_filt
//  Description : Bank of NUM_PADS bidirectional pad models. Tristate drive
//                path plus a synchronised, debounced input path per pad.
//  Revision    : 1.0  initial release
// ============================================================================
module pad_bank_inout_filt
  import pad_bank_pkg::*;
#(
  parameter int NUM_PADS    = 8,
  parameter int PAD_ATTR    = PAD_ATTR_W,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_PADS-1:0]                pad_in_i,
  input  logic [NUM_PADS-1:0]                pad_oe_i,
  inout  wire  [NUM_PADS-1:0]                pad_io,
  input  logic [NUM_PADS-1:0][PAD_ATTR-1:0]  pad_attributes_i,
  input  logic [NUM_PADS-1:0]                filt_en_i,
  input  logic [FILT_W-1:0]                  filt_thresh_i,
  output logic [NUM_PADS-1:0]                pad_out_o,
  output logic [NUM_PADS-1:0]                pad_sync_o,
  output logic [NUM_PADS-1:0]                pad_filt_o,
  output logic [NUM_PADS-1:0]                pad_rise_o,
  output logic [NUM_PADS-1:0]                pad_fall_o
);

  // Reject synchroniser depths outside the supported range at elaboration
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("pad_bank_inout_filt: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  end

  // Attributes are reserved for the silicon cell and have no effect here
  logic attr_unused;
  assign attr_unused = ^pad_attributes_i;

  // A driven pad reads back its own value
  assign pad_out_o = pad_io;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    // Tristate driver for this pad
    assign pad_io[i] = pad_oe_i[i] ? pad_in_i[i] : 1'bz;

    pad_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_deb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .d_i      (pad_io[i]),
      .en_i     (filt_en_i[i]),
      .thresh_i (filt_thresh_i),
      .sync_o   (pad_sync_o[i]),
      .filt_o   (pad_filt_o[i]),
      .rise_o   (pad_rise_o[i]),
      .fall_o   (pad_fall_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pad_bank_inout_filt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pad_bank_inout_filt
//  Description : Directed self-checking bench for pad_bank_inout_filt.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pad_bank_inout_filt;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        pad_in, pad_oe, filt_en;
  logic [3:0]        thresh;
  logic [7:0][15:0]  attr;
  logic [7:0]        ext_oe, ext_val;
  wire  [7:0]        pad_io;
  logic [7:0]        pad_out, pad_sync, pad_filt, pad_rise, pad_fall;

  // Second bank: one pad, deeper synchroniser, wide counter
  logic              pad_in2, pad_oe2, filt_en2, ext_oe2, ext_val2;
  logic [7:0]        thresh2;
  logic [0:0][15:0]  attr2;
  wire  [0:0]        pad_io2;
  logic [0:0]        out2, sync2, filt2, rise2, fall2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External pad drivers (board side)
  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign pad_io[i] = ext_oe[i] ? ext_val[i] : 1'bz;
  end
  assign pad_io2[0] = ext_oe2 ? ext_val2 : 1'bz;

  pad_bank_inout_filt dut (
    .clk_i(clk), .rst_i(rst), .pad_in_i(pad_in), .pad_oe_i(pad_oe), .pad_io(pad_io),
    .pad_attributes_i(attr), .filt_en_i(filt_en), .filt_thresh_i(thresh),
    .pad_out_o(pad_out), .pad_sync_o(pad_sync), .pad_filt_o(pad_filt),
    .pad_rise_o(pad_rise), .pad_fall_o(pad_fall)
  );

  pad_bank_inout_filt #(.NUM_PADS(1), .SYNC_STAGES(3), .FILT_W(8)) dut2 (
    .clk_i(clk), .rst_i(rst), .pad_in_i(pad_in2), .pad_oe_i(pad_oe2), .pad_io(pad_io2),
    .pad_attributes_i(attr2), .filt_en_i(filt_en2), .filt_thresh_i(thresh2),
    .pad_out_o(out2), .pad_sync_o(sync2), .pad_filt_o(filt2),
    .pad_rise_o(rise2), .pad_fall_o(fall2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] h;
    logic       v;
    rst = 1'b1; pad_in = '0; pad_oe = '0; filt_en = 8'hFF; thresh = 4'd0;
    attr = '1; ext_oe = 8'hEF; ext_val = '0;   // pad 4 left floating throughout
    pad_in2 = 1'b0; pad_oe2 = 1'b0; filt_en2 = 1'b1; thresh2 = 8'd255;
    attr2 = '0; ext_oe2 = 1'b1; ext_val2 = 1'b0;

    // 1. reset state and raw read-back of external drivers
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_sync", {24'd0, pad_sync}, 32'h0);
    chk("rst_filt", {24'd0, pad_filt}, 32'h0);
    chk("rst_rise", {24'd0, pad_rise}, 32'h0);
    chk("rst_fall", {24'd0, pad_fall}, 32'h0);
    ext_val = 8'hA5; #1;
    chk("raw_ext", {24'd0, pad_out & 8'hEF}, 32'hA5 & 32'hEF);
    ext_val = 8'h00; #1;
    chk("raw_ext0", {24'd0, pad_out & 8'hEF}, 32'h0);

    // 2. pad 3 driven by the bank, thresh=0
    ext_oe[3] = 1'b0; pad_oe[3] = 1'b1; pad_in[3] = 1'b1; #1;
    chk("drv_out3", {31'd0, pad_out[3]}, 32'd1);
    tick(); chk("drv_sync3_e1", {31'd0, pad_sync[3]}, 32'd0);
    tick(); chk("drv_sync3_e2", {31'd0, pad_sync[3]}, 32'd1);
            chk("drv_filt3_e2", {31'd0, pad_filt[3]}, 32'd0);
    tick(); chk("drv_filt3_e3", {31'd0, pad_filt[3]}, 32'd1);
            chk("drv_rise3_e3", {31'd0, pad_rise[3]}, 32'd1);
    tick(); chk("drv_rise3_e4", {31'd0, pad_rise[3]}, 32'd0);
            chk("drv_filt3_e4", {31'd0, pad_filt[3]}, 32'd1);

    // 3. thresh=5: 4-cycle glitch is rejected, 6-cycle level passes at edge 8
    thresh = 4'd5;
    ext_val[0] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k == 4) ext_val[0] = 1'b0;
      tick();
      chk("glitch_filt0", {31'd0, pad_filt[0]}, 32'd0);
      chk("glitch_rise0", {31'd0, pad_rise[0]}, 32'd0);
    end
    ext_val[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) chk("hold_filt0_e7", {31'd0, pad_filt[0]}, 32'd0);
      if (k == 8) begin
        chk("hold_filt0_e8", {31'd0, pad_filt[0]}, 32'd1);
        chk("hold_rise0_e8", {31'd0, pad_rise[0]}, 32'd1);
      end
      if (k == 9) chk("hold_rise0_e9", {31'd0, pad_rise[0]}, 32'd0);
    end
    ext_val[0] = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("settle_filt0", {31'd0, pad_filt[0]}, 32'd0);

    // 4. bypass on pad 1: filt is sync delayed one cycle
    filt_en[1] = 1'b0;
    h = 4'd0;
    for (int k = 0; k < 18; k++) begin
      v = ((k / 3) % 2) == 1;
      ext_val[1] = v;
      tick();
      h = {h[2:0], v};
      chk("byp_sync1", {31'd0, pad_sync[1]}, {31'd0, h[1]});
      chk("byp_filt1", {31'd0, pad_filt[1]}, {31'd0, h[2]});
      chk("byp_rise1", {31'd0, pad_rise[1]}, {31'd0, h[2] & ~h[3]});
      chk("byp_fall1", {31'd0, pad_fall[1]}, {31'd0, ~h[2] & h[3]});
    end

    // 5. reset mid-count on pad 2 discards the count
    ext_val[2] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_filt2", {31'd0, pad_filt[2]}, 32'd0);
    chk("mid_rst_rise2", {31'd0, pad_rise[2]}, 32'd0);
    chk("mid_rst_sync2", {31'd0, pad_sync[2]}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) chk("rel_rise_all", {24'd0, pad_rise}, 32'h0);
      if (k == 7) chk("post_rst_filt2_e7", {31'd0, pad_filt[2]}, 32'd0);
      if (k == 8) begin
        chk("post_rst_filt2_e8", {31'd0, pad_filt[2]}, 32'd1);
        chk("post_rst_rise2_e8", {31'd0, pad_rise[2]}, 32'd1);
      end
    end

    // 6. floating pad 4 reads 0 with no unknowns anywhere
    for (int k = 0; k < 4; k++) tick();
    chk("z_sync4", {31'd0, pad_sync[4]}, 32'd0);
    chk("z_filt4", {31'd0, pad_filt[4]}, 32'd0);
    chk("z_nox", {31'd0, $isunknown({pad_sync, pad_filt, pad_rise, pad_fall})}, 32'd0);

    // 6b. single-pad bank, 3 stages, thresh=255: latency 3+256 edges
    ext_val2 = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      tick();
      if (k == 2)   chk("b2_sync_e2", {31'd0, sync2[0]}, 32'd0);
      if (k == 3)   chk("b2_sync_e3", {31'd0, sync2[0]}, 32'd1);
      if (k == 258) chk("b2_filt_e258", {31'd0, filt2[0]}, 32'd0);
      if (k == 259) begin
        chk("b2_filt_e259", {31'd0, filt2[0]}, 32'd1);
        chk("b2_rise_e259", {31'd0, rise2[0]}, 32'd1);
      end
      if (k == 260) chk("b2_rise_e260", {31'd0, rise2[0]}, 32'd0);
    end
    chk("b2_nox", {31'd0, $isunknown({sync2, filt2, rise2, fall2})}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
